// File: rtl/rt_imp_mac_pipe.sv
// rt_imp_mac_pipe: parametrised valid-tagged pipelined multiplier / multiply-accumulate with optional saturation
module rt_imp_mac_pipe #(
  parameter int ID = 1,
  parameter int DIN0_WIDTH = 12,
  parameter int DIN1_WIDTH = 9,
  parameter bit DIN0_SIGNED = 0,
  parameter bit DIN1_SIGNED = 1,
  parameter int DOUT_WIDTH = 21,
  parameter int NUM_STAGE = 4,
  parameter int MODE = 0,
  parameter bit SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_first,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_valid,
  output logic                  out_ovf
);
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int XW = PW > DOUT_WIDTH + 1 ? PW : DOUT_WIDTH + 1;
  localparam int D = NUM_STAGE - 2 + 0 * ID;
  logic [DIN0_WIDTH-1:0] a_q;
  logic [DIN1_WIDTH-1:0] b_q;
  logic v1, f1, ovf;
  logic [PW-1:0] a_x, b_x, m;
  logic [PW-1:0] p_q [D];
  logic [D-1:0] v_q, f_q;
  logic signed [XW-1:0] pe;
  logic signed [DOUT_WIDTH:0] pa, sum;
  logic [DOUT_WIDTH-1:0] res;
  assign a_x = {{(DIN1_WIDTH + 1){DIN0_SIGNED & a_q[DIN0_WIDTH-1]}}, a_q};
  assign b_x = {{(DIN0_WIDTH + 1){DIN1_SIGNED & b_q[DIN1_WIDTH-1]}}, b_q};
  assign m = a_x * b_x;
  assign pe = XW'($signed(p_q[D-1]));
  assign pa = pe[DOUT_WIDTH:0];
  assign sum = (f_q[D-1] ? '0 : {dout[DOUT_WIDTH-1], dout}) + pa;
  always_comb begin
    ovf = MODE == 1 ? sum[DOUT_WIDTH] ^ sum[DOUT_WIDTH-1] : pe != XW'($signed(pe[DOUT_WIDTH-1:0]));
    res = MODE == 0 ? pe[DOUT_WIDTH-1:0] :
          ovf && SATURATE ? {sum[DOUT_WIDTH], {(DOUT_WIDTH - 1){~sum[DOUT_WIDTH]}}} : sum[DOUT_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      v1 <= 1'b0;
      f1 <= 1'b0;
      v_q <= '0;
      f_q <= '0;
      for (int i = 0; i < D; i++) p_q[i] <= '0;
      dout <= '0;
      out_valid <= 1'b0;
      out_ovf <= 1'b0;
    end else if (ce) begin
      a_q <= din0;
      b_q <= din1;
      v1 <= in_valid;
      f1 <= acc_first;
      p_q[0] <= m;
      v_q[0] <= v1;
      f_q[0] <= f1;
      for (int i = 1; i < D; i++) begin
        p_q[i] <= p_q[i-1];
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
      end
      out_valid <= v_q[D-1];
      out_ovf <= v_q[D-1] & ovf;
      if (v_q[D-1]) dout <= res;
    end
  end
endmodule

// File: tb/tb_rt_imp_mac_pipe.sv
// tb_rt_imp_mac_pipe: scoreboard bench driving five parameterisations of rt_imp_mac_pipe
module tb_rt_imp_mac_pipe;
  typedef struct {
    logic [20:0] d;
    logic o;
    int due;
  } exp_t;
  int ns [5] = '{4, 4, 4, 3, 8};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  logic iv [5];
  logic f [5];
  logic [11:0] a [5];
  logic [8:0] b [5];
  logic [20:0] dout [5];
  logic ov [5];
  logic of [5];
  exp_t sb [5][$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  int ecnt = 0;
  logic last_en = 1'b0;
  always #5 clk = ~clk;
  rt_imp_mac_pipe u0 (.clk(clk), .reset(reset), .ce(ce), .in_valid(iv[0]), .din0(a[0]), .din1(b[0]),
    .acc_first(f[0]), .dout(dout[0]), .out_valid(ov[0]), .out_ovf(of[0]));
  rt_imp_mac_pipe #(.MODE(1), .SATURATE(1)) u1 (.clk(clk), .reset(reset), .ce(ce), .in_valid(iv[1]),
    .din0(a[1]), .din1(b[1]), .acc_first(f[1]), .dout(dout[1]), .out_valid(ov[1]), .out_ovf(of[1]));
  rt_imp_mac_pipe #(.MODE(1), .SATURATE(0)) u2 (.clk(clk), .reset(reset), .ce(ce), .in_valid(iv[2]),
    .din0(a[2]), .din1(b[2]), .acc_first(f[2]), .dout(dout[2]), .out_valid(ov[2]), .out_ovf(of[2]));
  rt_imp_mac_pipe #(.NUM_STAGE(3), .DIN0_SIGNED(1), .DIN1_SIGNED(0)) u3 (.clk(clk), .reset(reset), .ce(ce),
    .in_valid(iv[3]), .din0(a[3]), .din1(b[3]), .acc_first(f[3]), .dout(dout[3]), .out_valid(ov[3]), .out_ovf(of[3]));
  rt_imp_mac_pipe #(.NUM_STAGE(8), .DIN0_SIGNED(1), .DIN1_SIGNED(0)) u4 (.clk(clk), .reset(reset), .ce(ce),
    .in_valid(iv[4]), .din0(a[4]), .din1(b[4]), .acc_first(f[4]), .dout(dout[4]), .out_valid(ov[4]), .out_ovf(of[4]));
  always @(posedge clk) begin
    last_en <= ce && !reset;
    if (ce && !reset) ecnt <= ecnt + 1;
  end
  always @(negedge clk) begin
    if (last_en) begin
      for (int k = 0; k < 5; k++) begin
        if (ov[k]) begin
          tests++;
          if (sb[k].size() == 0) begin
            fails++;
            $display("FAIL u%0d spurious out_valid: dout=%0d at edge %0d, none expected", k, $signed(dout[k]), ecnt);
          end else begin
            e = sb[k].pop_front();
            if (dout[k] !== e.d || of[k] !== e.o || ecnt != e.due) begin
              fails++;
              $display("FAIL u%0d result: dout=%0d ovf=%b edge=%0d, expected dout=%0d ovf=%b edge=%0d",
                k, $signed(dout[k]), of[k], ecnt, $signed(e.d), e.o, e.due);
            end
          end
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) iv[k] = 1'b0;
  endtask
  task automatic issue(int k, logic [11:0] x, logic [8:0] y, logic fst, int d, logic o);
    a[k] = x;
    b[k] = y;
    f[k] = fst;
    iv[k] = 1'b1;
    sb[k].push_back('{21'(d), o, ecnt + ns[k]});
  endtask
  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  initial begin
    for (int k = 0; k < 5; k++) begin
      iv[k] = 1'b0;
      f[k] = 1'b0;
      a[k] = '0;
      b[k] = '0;
    end
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("u%0d reset dout", k), int'($signed(dout[k])), 0);
      chk($sformatf("u%0d reset out_valid", k), int'(ov[k]), 0);
    end
    issue(0, 12'd4095, 9'h100, 1'b0, -1048320, 1'b0);
    tick();
    issue(0, 12'd7, 9'd3, 1'b0, 21, 1'b0);
    tick();
    repeat (6) tick();
    for (int k = 1; k < 3; k++) issue(k, 12'd10, 9'd3, 1'b1, 30, 1'b0);
    tick();
    for (int k = 1; k < 3; k++) issue(k, 12'd5, 9'h1FE, 1'b0, 20, 1'b0);
    tick();
    for (int k = 1; k < 3; k++) issue(k, 12'd100, 9'd100, 1'b0, 10020, 1'b0);
    tick();
    repeat (6) tick();
    chk("u1 bubble hold dout", int'($signed(dout[1])), 10020);
    chk("u1 bubble out_valid", int'(ov[1]), 0);
    chk("u1 bubble out_ovf", int'(of[1]), 0);
    chk("u2 bubble hold dout", int'($signed(dout[2])), 10020);
    issue(1, 12'd4095, 9'd255, 1'b1, 1044225, 1'b0);
    issue(2, 12'd4095, 9'd255, 1'b1, 1044225, 1'b0);
    tick();
    issue(1, 12'd4095, 9'd255, 1'b0, 1048575, 1'b1);
    issue(2, 12'd4095, 9'd255, 1'b0, -8702, 1'b1);
    tick();
    repeat (6) tick();
    issue(0, 12'd100, 9'd50, 1'b0, 5000, 1'b0);
    repeat (3) tick();
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("u0 stall out_valid", int'(ov[0]), 0);
      chk("u0 stall dout", int'($signed(dout[0])), 21);
    end
    ce = 1'b1;
    tick();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("u0 held out_valid", int'(ov[0]), 1);
      chk("u0 held dout", int'($signed(dout[0])), 5000);
    end
    ce = 1'b1;
    tick();
    chk("u0 no duplicate pulse", int'(ov[0]), 0);
    issue(1, 12'd1, 9'd1, 1'b1, 1, 1'b0);
    tick();
    issue(1, 12'd2, 9'd2, 1'b0, 5, 1'b0);
    tick();
    issue(1, 12'd3, 9'd3, 1'b0, 14, 1'b0);
    tick();
    ce = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) sb[k].delete();
    chk("u1 after reset dout", int'($signed(dout[1])), 0);
    chk("u1 after reset out_valid", int'(ov[1]), 0);
    ce = 1'b1;
    repeat (8) tick();
    issue(1, 12'd6, 9'd7, 1'b0, 42, 1'b0);
    tick();
    repeat (6) tick();
    issue(3, 12'hFFF, 9'd511, 1'b0, -511, 1'b0);
    issue(4, 12'hFFF, 9'd511, 1'b0, -511, 1'b0);
    tick();
    repeat (10) tick();
    for (int i = 0; i < 20; i++) begin
      logic [11:0] x;
      logic [8:0] y;
      int p;
      x = 12'($urandom);
      y = 9'($urandom);
      p = int'($signed(x)) * int'(y);
      issue(3, x, y, 1'b0, p, 1'b0);
      issue(4, x, y, 1'b0, p, 1'b0);
      tick();
    end
    repeat (12) tick();
    for (int k = 0; k < 5; k++) chk($sformatf("u%0d pending results", k), sb[k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rt_imp_mac_pipe.md
Name: rt_imp_mac_pipe

Overview:
Parametrised pipelined multiplier / multiply-accumulate unit for HLS-generated datapaths; successor to the fixed 12ns x 9s, 4-stage DSP48 multiplier.
- Operand widths, per-operand signedness, output width and pipeline depth are generics.
- Adds a valid-tagged pipeline, a real synchronous reset, an accumulate mode with first-beat clear, and optional saturation with an overflow flag.
- Sits between HLS datapath registers; maps to one DSP48 for default widths.

Parameters:
ID, 1, instance tag, no functional effect
DIN0_WIDTH, 12, width of din0
DIN1_WIDTH, 9, width of din1
DIN0_SIGNED, 0, 1 = din0 is two's complement, 0 = unsigned
DIN1_SIGNED, 1, 1 = din1 is two's complement, 0 = unsigned
DOUT_WIDTH, 21, result / accumulator width, always interpreted signed
NUM_STAGE, 4, total latency in ce-enabled cycles, legal range 3..8
MODE, 0, 0 = multiply only, 1 = multiply-accumulate
SATURATE, 0, MODE 1 only: 1 = clamp accumulator to signed DOUT range, 0 = wrap

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
ce  in  1  clock enable; 0 freezes every register, including valid and accumulator
in_valid  in  1  din0/din1/acc_first qualify a beat
din0  in  DIN0_WIDTH  operand A
din1  in  DIN1_WIDTH  operand B
acc_first  in  1  MODE 1: this beat restarts the accumulator (acc = product); ignored in MODE 0
dout  out  DOUT_WIDTH  product (MODE 0) or running sum (MODE 1)
out_valid  out  1  dout updated this cycle, one pulse per accepted beat
out_ovf  out  1  valid with out_valid; result overflowed DOUT range (clamped if SATURATE=1, wrapped if SATURATE=0)

Behaviour:
- Reset: when reset=1 on a clock edge, every register is cleared regardless of ce: dout=0, out_valid=0, out_ovf=0, accumulator=0, all in-flight beats discarded. Reset has priority over ce.
- Beat acceptance: a beat is accepted on an edge with ce=1, reset=0, in_valid=1. No backpressure; a new beat is accepted every enabled cycle.
- Pipeline: stage 1 registers operands, valid and acc_first. Stage 2 forms the full-precision product, width DIN0_WIDTH+DIN1_WIDTH+1. Each operand is extended to one extra bit: sign-extended if its SIGNED=1, zero-extended if 0. Stages 3..NUM_STAGE-1 are delay registers. Stage NUM_STAGE produces the result. Latency from accepted beat to out_valid is exactly NUM_STAGE enabled edges.
- ce=0: no stage advances; outputs hold their values, including an asserted out_valid. Beats are counted in enabled edges only.
- MODE 0: dout = product resized to DOUT_WIDTH (sign-extend, or truncate to the low bits). out_ovf=1 when truncation changes the signed value.
- MODE 1: the next result is product if acc_first=1, else acc + product, computed at DOUT_WIDTH+1 bits. On overflow of the signed DOUT_WIDTH range: SATURATE=1 clamps to 2^(DOUT_WIDTH-1)-1 or -2^(DOUT_WIDTH-1); SATURATE=0 keeps the low DOUT_WIDTH bits. In both cases out_ovf=1. The product is resized to DOUT_WIDTH+1 bits before the add. acc and dout are the same register.
- Bubbles: when no valid beat reaches the final stage, out_valid=0, out_ovf=0, and dout/acc hold. Bubbles never disturb the accumulator.
- First beat after reset in MODE 1 without acc_first: the accumulator starts from 0.

Test Plan:
1. Defaults, MODE 0: din0=4095, din1=-256, single beat, ce=1 -> out_valid pulses exactly 4 cycles later, dout=-1048320, out_ovf=0. Then din0=7, din1=3 -> dout=21.
2. MODE 1: beats (10,3,first=1), (5,-2,0), (100,100,0) back-to-back -> dout 30, 20, 10020 on consecutive out_valid cycles. Then a bubble -> dout holds 10020, out_valid=0.
3. MODE 1, SATURATE=1: (4095,255,first=1), (4095,255,0) -> dout 1044225 then 1048575 with out_ovf=1. Same stimulus with SATURATE=0 -> second result -8702, out_ovf=1.
4. ce stall: beat issued, then ce low for 5 cycles mid-pipeline -> outputs frozen throughout; out_valid appears after the 4th enabled edge with the correct product; no duplicate pulse.
5. Reset mid-operation: 3 beats in flight, reset=1 for one cycle with ce=0 -> next cycle dout=0, out_valid=0; none of the 3 beats ever emerges; the following MODE 1 beat without acc_first yields dout=product.
6. NUM_STAGE=3 and 8, DIN0_SIGNED=1, DIN1_SIGNED=0: din0=-1, din1=511 -> dout=-511 at the matching latency; continuous streaming of 20 random beats matches a reference model cycle-for-cycle.
